// File: rtl/moonbase_bus_bridge.sv
// moonbase_bus_bridge: demuxes the CPU io_out bus into an address latch, a 128x4 RAM and a strobe FIFO.
// Latency: RAM read 0 cycles from addr_q, write lands next edge; strobe to out_valid 1 cycle.
// Backpressure: out_ready stalls the FIFO head; a strobe arriving while full is dropped and flags overflow.

module moonbase_bus_bridge_fifo #(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_dat_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_dat_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en_i) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en_i, rd_en_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    assign empty_o  = (cnt_q == '0);
    assign full_o   = (cnt_q == CW'(DEPTH));
    assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

module moonbase_bus_bridge #(
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        cpu_out,
    output logic [3:0]        cpu_rdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [3:0]        ld_data,
    output logic [3:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
);
    localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

    logic [3:0]        ram_q [RAM_DEPTH];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dstrb_prev_q, dstrb_prev_d;
    logic              overflow_q, overflow_d;

    logic addr_phase, data_phase, cpu_we, dstrb, push, pop;
    logic fifo_wr, fifo_full, fifo_empty, drop;

    assign addr_phase = cpu_out[7];
    assign data_phase = !cpu_out[7];
    assign cpu_we     = data_phase && !cpu_out[5] && !ld_en;
    assign dstrb      = data_phase && !cpu_out[4];
    assign push       = dstrb && !dstrb_prev_q;
    assign pop        = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fifo_wr    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    always_comb begin
        addr_d       = addr_phase ? cpu_out[ADDR_W-1:0] : addr_q;
        dstrb_prev_d = dstrb;
        overflow_d   = overflow_q | drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q       <= '0;
            dstrb_prev_q <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            dstrb_prev_q <= dstrb_prev_d;
            overflow_q   <= overflow_d;
        end
    end

    // RAM survives reset so a preloaded program is kept across CPU resets.
    always_ff @(posedge clk) begin
        if (ld_en)       ram_q[ld_addr] <= ld_data;
        else if (cpu_we) ram_q[addr_q]  <= cpu_out[3:0];
    end

    assign cpu_rdata = ram_q[addr_q];

    moonbase_bus_bridge_fifo #(
        .W     (4),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (fifo_wr),
        .wr_dat_i (cpu_out[3:0]),
        .rd_en_i  (pop),
        .rd_dat_o (out_data),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_moonbase_bus_bridge.sv
// Directed bench for moonbase_bus_bridge: loader, address/data demux, RAM write/read, strobe FIFO, reset.
module tb_moonbase_bus_bridge;
    localparam logic [7:0] IDLE = 8'h70;   // data phase, wr_n=1, dstrb_n=1

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cpu_out;
    logic [3:0] cpu_rdata;
    logic       ld_en;
    logic [6:0] ld_addr;
    logic [3:0] ld_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    moonbase_bus_bridge #(.ADDR_W(7), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_out   (cpu_out),
        .cpu_rdata (cpu_rdata),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One strobe cycle with wr_n high carrying nibble n, then one idle cycle.
    task automatic strobe(input logic [3:0] n);
        cpu_out = {4'h6, n};
        tick();
        cpu_out = IDLE;
        tick();
    endtask

    logic [7:0] ld_vals [4];

    initial begin
        ld_vals[0] = 8'h8; ld_vals[1] = 8'h0; ld_vals[2] = 8'hC; ld_vals[3] = 8'hF;
        rst = 1'b1; cpu_out = IDLE; ld_en = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_overflow",  overflow,  0);
        rst = 1'b0;
        tick();

        // Loader preload RAM[0..3] = 8,0,C,F
        for (int i = 0; i < 4; i++) begin
            ld_en = 1'b1; ld_addr = 7'(i); ld_data = ld_vals[i][3:0];
            tick();
        end
        ld_en = 1'b0;
        cpu_out = 8'h82; tick(); chk("rd_addr2", cpu_rdata, 4'hC);
        cpu_out = 8'h80; tick(); chk("rd_addr0", cpu_rdata, 4'h8);
        cpu_out = 8'h83; tick(); chk("rd_addr3", cpu_rdata, 4'hF);

        // Loader wins over a same-cycle CPU write to the same address
        cpu_out = 8'h15; ld_en = 1'b1; ld_addr = 7'd3; ld_data = 4'h6;
        tick();
        cpu_out = IDLE; ld_en = 1'b0;
        chk("ld_priority", cpu_rdata, 4'h6);

        // CPU write RAM[5] = A
        cpu_out = 8'h85; tick();
        cpu_out = 8'h1A; tick();
        cpu_out = IDLE;
        chk("wr_ram5", cpu_rdata, 4'hA);

        // Long strobe pushes exactly once
        cpu_out = 8'h67;
        chk("strb_pre_valid", out_valid, 0);
        tick();
        chk("strb_valid_1cyc", out_valid, 1);
        chk("strb_data", out_data, 4'h7);
        tick(); tick();
        cpu_out = IDLE; tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("strb_single_entry", out_valid, 0);
        chk("no_ram_write_on_strb", cpu_rdata, 4'hA);

        // Five strobes into a 4-deep FIFO
        for (int n = 1; n <= 5; n++) strobe(4'(n));
        chk("ovf_set", overflow, 1);
        chk("ovf_head", out_data, 4'h1);
        out_ready = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, 32'(n));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-drain
        for (int n = 9; n <= 12; n++) strobe(4'(n));
        out_ready = 1'b1; tick();
        chk("pre_rst_head", out_data, 4'hA);
        rst = 1'b1; #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ovf", overflow, 0);
        chk("async_rst_addr0", cpu_rdata, 4'h8);
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        cpu_out = 8'h85; tick(); cpu_out = IDLE;
        chk("ram_kept_rst", cpu_rdata, 4'hA);
        chk("rst_fifo_empty", out_valid, 0);

        // Full FIFO: push and pop in the same cycle
        for (int n = 1; n <= 4; n++) strobe(4'(n));
        cpu_out = 8'h65; out_ready = 1'b1;
        tick();
        cpu_out = IDLE; out_ready = 1'b0;
        chk("pp_no_ovf", overflow, 0);
        chk("pp_head", out_data, 4'h2);
        tick();
        strobe(4'h6);
        chk("pp_still_full", overflow, 1);
        out_ready = 1'b1;
        for (int n = 2; n <= 5; n++) begin
            chk("pp_drain", out_data, 32'(n));
            tick();
        end
        out_ready = 1'b0;
        chk("pp_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
